// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master issues req/addr; the slave answers with ready/rdata.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Pipelined MIPS instruction-fetch stage: owns the PC, talks to a variable-latency
// imem, fills IF/ID and arbitrates exception / branch / jump / interrupt redirects.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INST_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              irq,
  input  logic              exc,
  input  logic [ADDR_W-1:0] exc_pc,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pcp4,
  output logic              flush,
  output logic [ADDR_W-1:0] epc,
  output logic              epc_we
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t            state_q, state_d;
  logic              started_q;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_seq;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic              if_valid_d, flush_d, epc_we_d;
  logic [INST_W-1:0] if_inst_d;
  logic [ADDR_W-1:0] if_pc_d, if_pcp4_d, epc_d;
  logic              req, user_mode;
  logic              redir_hit, save_epc;
  logic [ADDR_W-1:0] target, epc_src;

  // Sequential increment stays inside the current half of the address space.
  function automatic logic [ADDR_W-1:0] seq_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1], a[ADDR_W-2:0] + (ADDR_W-1)'(4)};
  endfunction

  // User code may not jump into kernel space; kernel code may go anywhere.
  function automatic logic [ADDR_W-1:0] clip(input logic [ADDR_W-1:0] t, input logic user);
    return user ? {1'b0, t[ADDR_W-2:0]} : t;
  endfunction

  assign user_mode      = ~pc_q[ADDR_W-1];
  assign pc_seq         = seq_addr(pc_q);
  assign req            = started_q && (state_q != HOLD);
  assign imem.imem_req  = req;
  assign imem.imem_addr = !started_q         ? '0 :
                          (state_q == DROP)  ? drop_addr_q : pc_q;

  // Fixed-priority redirect select: exc > br_taken > jmp_valid > irq.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    redir_hit = 1'b1;
    target    = pc_q;
    save_epc  = 1'b0;
    epc_src   = exc_pc;
    if (exc) begin
      target   = EXC_VEC;
      save_epc = 1'b1;
    end else if (br_taken) begin
      target = clip(br_target, user_mode);
    end else if (jmp_valid) begin
      target = clip(jmp_target, user_mode);
    end else if (irq && user_mode) begin
      target   = IRQ_VEC;
      save_epc = 1'b1;
      epc_src  = pc_q;
    end else begin
      redir_hit = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_inst_d = hold_inst_q;
    if_valid_d  = if_valid;
    if_inst_d   = if_inst;
    if_pc_d     = if_pc;
    if_pcp4_d   = if_pcp4;
    flush_d     = 1'b0;
    epc_d       = epc;
    epc_we_d    = 1'b0;
    if (started_q) begin
      if (redir_hit) begin
        pc_d       = target;
        flush_d    = 1'b1;
        if_valid_d = 1'b0;
        if (save_epc) begin
          epc_d    = epc_src;
          epc_we_d = 1'b1;
        end
        // A request still in flight must be answered before the new one can go out.
        if (req && !imem.imem_ready) begin
          state_d     = DROP;
          drop_addr_d = imem.imem_addr;
        end else begin
          state_d = FETCH;
        end
      end else begin
        unique case (state_q)
          FETCH: begin
            if (imem.imem_ready) begin
              if (!stall) begin
                if_valid_d = 1'b1;
                if_inst_d  = imem.imem_rdata;
                if_pc_d    = pc_q;
                if_pcp4_d  = pc_seq;
                pc_d       = pc_seq;
              end else begin
                hold_inst_d = imem.imem_rdata;
                state_d     = HOLD;
              end
            end else if (!stall) begin
              if_valid_d = 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              if_valid_d = 1'b1;
              if_inst_d  = hold_inst_q;
              if_pc_d    = pc_q;
              if_pcp4_d  = pc_seq;
              pc_d       = pc_seq;
              state_d    = FETCH;
            end
          end
          DROP: begin
            if (imem.imem_ready) state_d = FETCH;
            if (!stall) if_valid_d = 1'b0;
          end
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      pc_q      <= RESET_VEC;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      if_pc     <= '0;
      if_pcp4   <= '0;
      flush     <= 1'b0;
      epc       <= '0;
      epc_we    <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      pc_q      <= pc_d;
      if_valid  <= if_valid_d;
      if_inst   <= if_inst_d;
      if_pc     <= if_pc_d;
      if_pcp4   <= if_pcp4_d;
      flush     <= flush_d;
      epc       <= epc_d;
      epc_we    <= epc_we_d;
    end
  end

  // NOTE: pure data holders need no reset; they are only read once a state marks them valid.
  always_ff @(posedge clk) begin
    hold_inst_q <= hold_inst_d;
    drop_addr_q <= drop_addr_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;

  typedef struct {
    bit          v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } ifid_t;

  logic        clk, reset, stall, br_taken, jmp_valid, irq, exc;
  logic [31:0] br_target, jmp_target, exc_pc;
  logic        if_valid, flush, epc_we;
  logic [31:0] if_inst, if_pc, if_pcp4, epc;

  fetch_unit_if #(.ADDR_W(32), .INST_W(32)) mem ();

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .irq(irq), .exc(exc), .exc_pc(exc_pc),
    .imem(mem),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pcp4(if_pcp4),
    .flush(flush), .epc(epc), .epc_we(epc_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs set by the scenarios and applied by step().
  bit          s_stall, s_br, s_jmp, s_irq, s_exc;
  logic [31:0] s_bt, s_jt, s_ep;
  int unsigned rdy_pct;

  // Reference model: what the fetch stage has in flight, what it is holding,
  // and what the architectural PC / IF/ID / EPC should be.
  bit          m_live;        // first post-reset edge has happened
  bit          m_buffered;    // an instruction was captured under stall
  bit          m_stale;       // the bus request in flight belongs to a killed path
  logic [31:0] m_pc, m_stale_addr, m_buf, m_epc;
  bit          m_flush, m_epc_we;
  ifid_t       m_ifid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] next_seq(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] user_clip(input logic [31:0] t);
    return m_pc[31] ? t : (t & 32'h7FFF_FFFF);
  endfunction

  function automatic bit exp_req();
    return m_live && !m_buffered;
  endfunction

  function automatic logic [31:0] exp_addr();
    if (!m_live) return 32'h0;
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_live = 0; m_buffered = 0; m_stale = 0;
    m_pc = RST_V; m_stale_addr = '0; m_buf = '0; m_epc = '0;
    m_flush = 0; m_epc_we = 0;
    m_ifid = '{v: 0, inst: '0, pc: '0, pcp4: '0};
  endtask

  task automatic deliver(input logic [31:0] inst);
    m_ifid = '{v: 1, inst: inst, pc: m_pc, pcp4: next_seq(m_pc)};
    m_pc   = next_seq(m_pc);
  endtask

  task automatic model_step(input bit rdy, input logic [31:0] rd);
    bit          take;
    bit          on_bus;
    logic [31:0] tgt;
    on_bus   = exp_req();
    m_flush  = 0;
    m_epc_we = 0;
    if (!m_live) begin
      m_live = 1;
      return;
    end
    take = 1;
    tgt  = m_pc;
    if (s_exc) begin
      tgt = EXC_V; m_epc = s_ep; m_epc_we = 1;
    end else if (s_br) begin
      tgt = user_clip(s_bt);
    end else if (s_jmp) begin
      tgt = user_clip(s_jt);
    end else if (s_irq && !m_pc[31]) begin
      tgt = IRQ_V; m_epc = m_pc; m_epc_we = 1;
    end else begin
      take = 0;
    end
    if (take) begin
      if (on_bus && !rdy) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_pc       = tgt;
      m_flush    = 1;
      m_ifid.v   = 0;
      m_buffered = 0;
    end else if (m_buffered) begin
      if (!s_stall) begin
        deliver(m_buf);
        m_buffered = 0;
      end
    end else if (m_stale) begin
      if (rdy) m_stale = 0;
      if (!s_stall) m_ifid.v = 0;
    end else if (rdy) begin
      if (!s_stall) deliver(rd);
      else begin
        m_buf = rd; m_buffered = 1;
      end
    end else if (!s_stall) begin
      m_ifid.v = 0;
    end
  endtask

  task automatic compare_all();
    check("req",      {63'd0, mem.imem_req}, {63'd0, exp_req()});
    check("addr",     {32'd0, mem.imem_addr}, {32'd0, exp_addr()});
    check("if_valid", {63'd0, if_valid}, {63'd0, m_ifid.v});
    check("if_inst",  {32'd0, if_inst}, {32'd0, m_ifid.inst});
    check("if_pc",    {32'd0, if_pc}, {32'd0, m_ifid.pc});
    check("if_pcp4",  {32'd0, if_pcp4}, {32'd0, m_ifid.pcp4});
    check("flush",    {63'd0, flush}, {63'd0, m_flush});
    check("epc",      {32'd0, epc}, {32'd0, m_epc});
    check("epc_we",   {63'd0, epc_we}, {63'd0, m_epc_we});
  endtask

  // Called at a falling edge: check outputs, drive the next cycle's inputs, advance the model.
  task automatic step();
    bit          rdy;
    logic [31:0] rd;
    compare_all();
    rdy = exp_req() && ($urandom_range(99) < rdy_pct);
    rd  = rdy ? inst_of(exp_addr()) : $urandom;
    stall          = s_stall;
    br_taken       = s_br;   br_target  = s_bt;
    jmp_valid      = s_jmp;  jmp_target = s_jt;
    irq            = s_irq;
    exc            = s_exc;  exc_pc     = s_ep;
    mem.imem_ready = rdy;
    mem.imem_rdata = rd;
    model_step(rdy, rd);
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    s_br = 0; s_jmp = 0; s_exc = 0;
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1 model_reset();
    check("rst_req_now", {63'd0, mem.imem_req}, 64'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    stall = 0; br_taken = 0; jmp_valid = 0; irq = 0; exc = 0;
    br_target = '0; jmp_target = '0; exc_pc = '0;
    mem.imem_ready = 0; mem.imem_rdata = '0;
    s_stall = 0; s_irq = 0; clear_pulses();
    s_bt = '0; s_jt = '0; s_ep = '0;
    rdy_pct = 100;
    model_reset();

    // Reset state, then sequential fetch with ready tied high.
    repeat (3) @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    reset = 1'b1;
    step();
    check("t1_addr0", {32'd0, mem.imem_addr}, {32'd0, RST_V});
    step();
    check("t1_addr1", {32'd0, mem.imem_addr}, 64'h8000_0004);
    check("t1_pc0", {32'd0, if_pc}, {32'd0, RST_V});
    check("t1_valid", {63'd0, if_valid}, 64'd1);
    step();
    check("t1_addr2", {32'd0, mem.imem_addr}, 64'h8000_0008);
    check("t1_pc1", {32'd0, if_pc}, 64'h8000_0004);

    // Stall arrives together with the response at 80000010.
    n = 0;
    while (exp_addr() != 32'h8000_0010 && n < 40) begin
      step();
      n++;
    end
    check("t2_reach", {32'd0, mem.imem_addr}, 64'h8000_0010);
    s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_req", {63'd0, mem.imem_req}, 64'd0);
      check("t2_frozen_pc", {32'd0, if_pc}, 64'h8000_000C);
    end
    s_stall = 0;
    step();
    check("t2_rel_pc", {32'd0, if_pc}, 64'h8000_0010);
    step();
    check("t2_next_pc", {32'd0, if_pc}, 64'h8000_0014);

    // Branch kills a waiting request at 00000040.
    s_jmp = 1; s_jt = 32'h0000_0040;
    step();
    clear_pulses();
    rdy_pct = 0;
    step();
    s_br = 1; s_bt = 32'h0000_0200;
    step();
    clear_pulses();
    check("t3_flush", {63'd0, flush}, 64'd1);
    check("t3_bubble", {63'd0, if_valid}, 64'd0);
    check("t3_old_addr", {32'd0, mem.imem_addr}, 64'h0000_0040);
    step();
    rdy_pct = 100;
    step();
    check("t3_new_addr", {32'd0, mem.imem_addr}, 64'h0000_0200);
    check("t3_dropped", {63'd0, if_valid}, 64'd0);
    step();
    check("t3_first_pc", {32'd0, if_pc}, 64'h0000_0200);

    // User-mode interrupt, then the same irq level in kernel mode.
    s_jmp = 1; s_jt = 32'h0000_0040;
    step();
    clear_pulses();
    rdy_pct = 0; s_irq = 1;
    step();
    s_irq = 0;
    check("t4_epc", {32'd0, epc}, 64'h0000_0040);
    check("t4_epc_we", {63'd0, epc_we}, 64'd1);
    rdy_pct = 100;
    step();
    check("t4_vec", {32'd0, mem.imem_addr}, {32'd0, IRQ_V});
    check("t4_we_pulse", {63'd0, epc_we}, 64'd0);
    s_irq = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_kernel_flush", {63'd0, flush}, 64'd0);
    end
    s_irq = 0;
    check("t4_epc_kept", {32'd0, epc}, 64'h0000_0040);

    // Exception beats a same-cycle branch.
    s_exc = 1; s_ep = 32'h0000_0100; s_br = 1; s_bt = 32'h0000_0300;
    step();
    clear_pulses();
    check("t5_epc", {32'd0, epc}, 64'h0000_0100);
    check("t5_epc_we", {63'd0, epc_we}, 64'd1);
    check("t5_vec", {32'd0, mem.imem_addr}, {32'd0, EXC_V});

    // User code cannot jump into kernel space; reset abandons a waiting request.
    s_jmp = 1; s_jt = 32'h0000_0500;
    step();
    s_jt = 32'h8000_1000;
    step();
    clear_pulses();
    check("t6_clip", {32'd0, mem.imem_addr}, 64'h0000_1000);
    rdy_pct = 0;
    step();
    step();
    reset_pulse();
    rdy_pct = 100;
    step();
    check("t6_restart", {32'd0, mem.imem_addr}, {32'd0, RST_V});
    check("t6_restart_req", {63'd0, mem.imem_req}, 64'd1);

    // Random traffic with the model checking every cycle.
    rdy_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      s_stall = ($urandom_range(3) == 0);
      s_br    = ($urandom_range(19) == 0);  s_bt = $urandom;
      s_jmp   = ($urandom_range(19) == 0);  s_jt = $urandom;
      s_exc   = ($urandom_range(39) == 0);  s_ep = $urandom;
      if ($urandom_range(9) == 0) s_irq = !s_irq;
      if (c % 997 == 500) reset_pulse();
      step();
    end
    s_stall = 0; s_irq = 0; clear_pulses();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
